// File: rtl/cpu_sched.sv
// rtl/cpu_sched.sv - Z80 clock-enable divider, 48K frame timebase, frame interrupt and ULA contention.
// Contention stalling is compiled in only when CPU_SCHED_CONTENTION_EN is defined.
module cpu_sched #(
  parameter int CLKDIV  = 8,
  parameter int HLINE   = 224,
  parameter int VLINES  = 312,
  parameter int INTLEN  = 32,
  parameter int VWIN_LO = 64,
  parameter int VWIN_HI = 256,
  parameter int HWIN    = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic        mreq,
  input  logic        iorq,
  output logic        cep,
  output logic        cen,
  output logic        mi,
  output logic [7:0]  hcount,
  output logic [8:0]  vcount,
  output logic        stall
);

  localparam int PW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLKDIV / 2);
  localparam logic [7:0]    H_LAST = 8'(HLINE - 1);
  localparam logic [8:0]    V_LAST = 9'(VLINES - 1);
  localparam logic [7:0]    H_INT  = 8'(INTLEN);
  localparam logic [8:0]    V_LO   = 9'(VWIN_LO);
  localparam logic [8:0]    V_HI   = 9'(VWIN_HI);
  localparam logic [7:0]    H_WIN  = 8'(HWIN);

  logic [PW-1:0] p_q, p_d;
  logic [7:0]    hcount_q, hcount_d;
  logic [8:0]    vcount_q, vcount_d;
  logic          cep_q, cep_d;
  logic          cen_q, cen_d;
  logic          mi_q, mi_d;
  logic          slot_start, slot_end;
  logic          creq, win;
  logic          stall_next, stall_o;
  logic          unused_addr;

  assign slot_start  = (p_q == '0);
  assign slot_end    = (p_q == P_LAST);
  assign unused_addr = ^a[13:1];

  assign creq = ((a[15:14] == 2'b01) && !mreq) || (!iorq && !a[0]);
  assign win  = (vcount_q >= V_LO) && (vcount_q < V_HI) &&
                (hcount_q < H_WIN) && (hcount_q[2:0] < 3'd6);

  always_comb begin
    p_d      = slot_end ? '0 : p_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (slot_end) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 9'd1;
      end else begin
        hcount_d = hcount_q + 8'd1;
      end
    end
    // mi follows the next timebase value so it falls on the clock h/v become 0
    mi_d  = !((vcount_d == 9'd0) && (hcount_d < H_INT));
    cep_d = slot_start && !stall_next;
    cen_d = (p_q == P_HALF) && !stall_o;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q      <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      cep_q    <= 1'b0;
      cen_q    <= 1'b0;
      mi_q     <= 1'b1;
    end else begin
      p_q      <= p_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      cep_q    <= cep_d;
      cen_q    <= cen_d;
      mi_q     <= mi_d;
    end
  end

`ifdef CPU_SCHED_CONTENTION_EN
  logic stall_q, stall_d;
  logic grant_q, grant_d;

  always_comb begin
    stall_next = win && creq && !grant_q;
    stall_d    = stall_q;
    grant_d    = grant_q;
    // grant marks an access that already took its one contention delay
    if (slot_start) begin
      stall_d = stall_next;
      if (mreq && iorq) begin
        grant_d = 1'b0;
      end else if (creq && !stall_next) begin
        grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      grant_q <= grant_d;
    end
  end

  assign stall_o = stall_q;
`else
  logic unused_cont;
  assign stall_next  = 1'b0;
  assign stall_o     = 1'b0;
  assign unused_cont = creq ^ win;
`endif

  assign cep    = cep_q;
  assign cen    = cen_q;
  assign mi     = mi_q;
  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign stall  = stall_o;

endmodule

// File: tb/tb_cpu_sched.sv
// tb/tb_cpu_sched.sv - self-checking bench for cpu_sched on a shortened frame geometry.
module tb_cpu_sched;

  localparam int CD  = 8;
  localparam int HL  = 136;
  localparam int VL  = 8;
  localparam int IL  = 32;
  localparam int VLO = 2;
  localparam int VHI = 6;
  localparam int HW  = 128;
  localparam int NF  = CD * HL * VL;
  localparam int NV  = 17;
`ifdef CPU_SCHED_CONTENTION_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct packed {
    int          v;
    int          h;
    logic [15:0] a;
    logic        mq;
    logic        iq;
    int          hold;
    int          exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic        mreq, iorq;
  logic        cep, cen, mi, stall;
  logic [7:0]  hcount;
  logic [8:0]  vcount;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  int   lowcnt [0:7];
  vec_t tbl [0:NV-1];

  always #5 clock = ~clock;

  cpu_sched #(
    .CLKDIV(CD), .HLINE(HL), .VLINES(VL), .INTLEN(IL),
    .VWIN_LO(VLO), .VWIN_HI(VHI), .HWIN(HW)
  ) dut (
    .clock(clock), .reset(reset), .a(a), .mreq(mreq), .iorq(iorq),
    .cep(cep), .cen(cen), .mi(mi), .hcount(hcount), .vcount(vcount), .stall(stall)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit creq_f(logic [15:0] aa, logic mq, logic iq);
    return ((aa[15:14] == 2'b01) && !mq) || (!iq && !aa[0]);
  endfunction

  function automatic bit in_win(int t);
    int h = t % HL;
    int v = (t / HL) % VL;
    return (v >= VLO) && (v < VHI) && (h < HW) && ((h % 8) < 6);
  endfunction

  function automatic int cur_t();
    return k / CD;
  endfunction
  function automatic int cur_h();
    return cur_t() % HL;
  endfunction
  function automatic int cur_v();
    return (cur_t() / HL) % VL;
  endfunction

  // es: whether the T-state whose decision edge is the next p==0 is expected stalled
  task automatic tick(input bit es);
    int t, h, v;
    logic [20:0] e;
    @(posedge clock);
    #1;
    k++;
    t = k / CD;
    h = t % HL;
    v = (t / HL) % VL;
    e = {h[7:0], v[8:0], !((v == 0) && (h < IL)), ((k % CD) == 1) && !es,
         ((k % CD) == (CD / 2 + 1)) && !es, es};
    if (mi === 1'b0 && (k / NF) < 8) lowcnt[k / NF]++;
    cmp($sformatf("tick k=%0d {h,v,mi,cep,cen,stall}", k),
        32'({hcount, vcount, mi, cep, cen, stall}), 32'(e));
  endtask

  task automatic slot(input logic [15:0] aa, input logic mq, input logic iq,
                      input bit es, output int st);
    a    = aa;
    mreq = mq;
    iorq = iq;
    st   = 0;
    for (int i = 0; i < CD; i++) begin
      tick(es);
      if (i == 0 && stall === 1'b1) st = 1;
    end
  endtask

  task automatic access(input logic [15:0] aa, input logic mq, input logic iq,
                        input int nst, input int hold, output int got);
    int st;
    got = 0;
    for (int s = 0; s < nst + hold; s++) begin
      slot(aa, mq, iq, s < nst, st);
      got += st;
    end
    slot(16'h0000, 1'b1, 1'b1, 1'b0, st);
    got += st;
  endtask

  task automatic wait_to(input int v0, input int h0);
    int st, n;
    n = 0;
    while (!(cur_v() == v0 && cur_h() == h0) && n <= HL * VL) begin
      slot(16'h0000, 1'b1, 1'b1, 1'b0, st);
      n++;
    end
    if (n > HL * VL) begin
      checks++;
      errors++;
      $display("FAIL wait_to: position v=%0d h=%0d not reached, got v=%0d h=%0d", v0, h0, cur_v(), cur_h());
    end
  endtask

  initial begin
    int got, st, nst, hold, kind, gap, t0;
    logic [15:0] ra;
    logic rm, ri;

    //            v  h    a         mq    iq    hold exp
    tbl[0]  = '{1, 0,   16'h4000, 1'b0, 1'b1, 1, 0};
    tbl[1]  = '{2, 0,   16'h4000, 1'b0, 1'b1, 4, 6};
    tbl[2]  = '{3, 0,   16'h4000, 1'b0, 1'b1, 1, 6};
    tbl[3]  = '{3, 9,   16'h5123, 1'b0, 1'b1, 1, 5};
    tbl[4]  = '{3, 18,  16'h4000, 1'b0, 1'b1, 1, 4};
    tbl[5]  = '{3, 27,  16'h7FFF, 1'b0, 1'b1, 1, 3};
    tbl[6]  = '{3, 36,  16'h4000, 1'b0, 1'b1, 1, 2};
    tbl[7]  = '{3, 45,  16'h4000, 1'b0, 1'b1, 1, 1};
    tbl[8]  = '{3, 54,  16'h4000, 1'b0, 1'b1, 1, 0};
    tbl[9]  = '{3, 63,  16'h4000, 1'b0, 1'b1, 1, 0};
    tbl[10] = '{3, 72,  16'h8000, 1'b0, 1'b1, 1, 0};
    tbl[11] = '{3, 120, 16'h4000, 1'b0, 1'b1, 1, 6};
    tbl[12] = '{3, 128, 16'h4000, 1'b0, 1'b1, 1, 0};
    tbl[13] = '{4, 2,   16'h00FE, 1'b1, 1'b0, 1, 4};
    tbl[14] = '{4, 18,  16'h00FF, 1'b1, 1'b0, 1, 0};
    tbl[15] = '{5, 40,  16'h4000, 1'b0, 1'b1, 1, 6};
    tbl[16] = '{6, 0,   16'h4000, 1'b0, 1'b1, 1, 0};

    for (int i = 0; i < 8; i++) lowcnt[i] = 0;
    reset = 1'b0;
    a     = 16'h0000;
    mreq  = 1'b1;
    iorq  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    cmp("reset_state", 32'({hcount, vcount, mi, cep, cen, stall}), 32'({8'd0, 9'd0, 1'b1, 3'b000}));
    reset = 1'b1;
    k = 0;

    for (int i = 0; i < NV; i++) begin
      wait_to(tbl[i].v, tbl[i].h);
      nst = CONT ? tbl[i].exp : 0;
      access(tbl[i].a, tbl[i].mq, tbl[i].iq, nst, tbl[i].hold, got);
      cmp($sformatf("table%0d_stalls", i), got, nst);
    end

    while (k < 3 * NF) slot(16'h0000, 1'b1, 1'b1, 1'b0, st);
    cmp("mi_low_clocks_frame1", lowcnt[1], IL * CD);
    cmp("mi_low_clocks_frame2", lowcnt[2], IL * CD);

    while (cur_v() < 5) begin
      gap = $urandom_range(1, 3);
      repeat (gap) slot(16'h0000, 1'b1, 1'b1, 1'b0, st);
      kind = $urandom_range(0, 3);
      ra   = 16'($urandom);
      case (kind)
        0:       begin ra[15:14] = 2'b01; rm = 1'b0; ri = 1'b1; end
        1:       begin ra[15]    = 1'b1;  rm = 1'b0; ri = 1'b1; end
        2:       begin ra[0]     = 1'b0;  rm = 1'b1; ri = 1'b0; end
        default: begin ra[0]     = 1'b1;  rm = 1'b1; ri = 1'b0; end
      endcase
      nst = 0;
      t0  = cur_t();
      if (CONT && creq_f(ra, rm, ri)) begin
        while (in_win(t0 + nst)) nst++;
      end
      hold = $urandom_range(1, 3);
      access(ra, rm, ri, nst, hold, got);
      cmp($sformatf("random_stalls a=%04h mreq=%0b iorq=%0b t=%0d", ra, rm, ri, t0), got, nst);
    end

    wait_to(5, 40);
    nst = CONT ? 1 : 0;
    slot(16'h4000, 1'b0, 1'b1, nst[0], st);
    slot(16'h4000, 1'b0, 1'b1, nst[0], st);
    tick(nst[0]);
    cmp("stall_before_reset", 32'(stall), nst);
    #2;
    reset = 1'b0;
    a     = 16'h0000;
    mreq  = 1'b1;
    iorq  = 1'b1;
    #1;
    cmp("reset_mid_stall", 32'({hcount, vcount, mi, cep, cen, stall}), 32'({8'd0, 9'd0, 1'b1, 3'b000}));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    k = 0;
    tick(1'b0);
    cmp("first_cep_after_reset", 32'({cep, hcount, vcount}), 32'({1'b1, 8'd0, 9'd0}));
    repeat (15) tick(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
